// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring division, 34-cycle fixed latency.
// Optional MULDIV_FAST_SPECIAL_EN: divide-by-zero, signed overflow and zero-operand multiplies bypass CALC.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [4:0]      rd_addr,
    output logic            busy,
    output logic            done,
    output logic            wb_en,
    output logic [4:0]      wb_addr,
    output logic [XLEN-1:0] wb_data
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      state_q;
    logic [2:0]  op_q;
    logic [4:0]  rd_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] rem_q;
    logic [63:0] prod_q;
    logic [5:0]  cnt_q;
    logic        neg_q;
    logic        rneg_q;
    logic        div0_q;
`ifdef MULDIV_FAST_SPECIAL_EN
    logic        spec_q;
    logic [31:0] spec_res_q;
    logic        is_special;
    logic        op_div0;
    logic        op_ovf;
    logic        op_mzero;
    logic [31:0] spec_res;
`endif

    logic        signed_a;
    logic        signed_b;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [32:0] mul_sum;
    logic [63:0] prod_mul_d;
    logic [32:0] rem_sh;
    logic        rem_ge;
    logic [31:0] rem_d;
    logic [63:0] prod_div_d;
    logic [63:0] prod_sgn;
    logic [31:0] quo_sgn;
    logic [31:0] rem_sgn;
    logic [31:0] fix_res;

    // Operand signedness and magnitudes for the incoming request.
    always_comb begin
        signed_a = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                   (funct3 == 3'b100) || (funct3 == 3'b110);
        signed_b = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
        a_neg    = signed_a && rs1_val[31];
        b_neg    = signed_b && rs2_val[31];
        a_mag    = a_neg ? (32'd0 - rs1_val) : rs1_val;
        b_mag    = b_neg ? (32'd0 - rs2_val) : rs2_val;
`ifdef MULDIV_FAST_SPECIAL_EN
        op_div0    = funct3[2] && (rs2_val == 32'd0);
        op_ovf     = ((funct3 == 3'b100) || (funct3 == 3'b110)) &&
                     (rs1_val == 32'h8000_0000) && (rs2_val == 32'hFFFF_FFFF);
        op_mzero   = !funct3[2] && ((rs1_val == 32'd0) || (rs2_val == 32'd0));
        is_special = op_div0 || op_ovf || op_mzero;
        spec_res   = op_div0 ? (funct3[1] ? rs1_val : 32'hFFFF_FFFF) :
                     op_ovf  ? (funct3[1] ? 32'd0 : 32'h8000_0000) : 32'd0;
`endif
    end

    // One iteration of each datapath; the multiplier lives in the low half of prod_q,
    // the dividend/quotient shares the same low half during division.
    always_comb begin
        mul_sum    = {1'b0, prod_q[63:32]} + (prod_q[0] ? {1'b0, a_q} : 33'd0);
        prod_mul_d = {mul_sum, prod_q[31:1]};
        rem_sh     = {rem_q, prod_q[31]};
        rem_ge     = (rem_sh >= {1'b0, b_q});
        rem_d      = rem_ge ? 32'(rem_sh - {1'b0, b_q}) : rem_sh[31:0];
        prod_div_d = {32'd0, prod_q[30:0], rem_ge};
    end

    // Sign correction and final result selection.
    always_comb begin
        prod_sgn = neg_q  ? (64'd0 - prod_q) : prod_q;
        quo_sgn  = neg_q  ? (32'd0 - prod_q[31:0]) : prod_q[31:0];
        rem_sgn  = rneg_q ? (32'd0 - rem_q) : rem_q;
        case (op_q)
            3'b000:                 fix_res = prod_sgn[31:0];
            3'b001, 3'b010, 3'b011: fix_res = prod_sgn[63:32];
            3'b100, 3'b101:         fix_res = div0_q ? 32'hFFFF_FFFF : quo_sgn;
            default:                fix_res = rem_sgn;
        endcase
`ifdef MULDIV_FAST_SPECIAL_EN
        if (spec_q) begin
            fix_res = spec_res_q;
        end else begin
            fix_res = fix_res;
        end
`endif
    end

    // Control FSM with registered outputs and datapath state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= 3'd0;
            rd_q    <= 5'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            rem_q   <= 32'd0;
            prod_q  <= 64'd0;
            cnt_q   <= 6'd0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            div0_q  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            wb_en   <= 1'b0;
            wb_addr <= 5'd0;
            wb_data <= 32'd0;
`ifdef MULDIV_FAST_SPECIAL_EN
            spec_q     <= 1'b0;
            spec_res_q <= 32'd0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        op_q    <= funct3;
                        rd_q    <= rd_addr;
                        a_q     <= a_mag;
                        b_q     <= b_mag;
                        rem_q   <= 32'd0;
                        prod_q  <= funct3[2] ? {32'd0, a_mag} : {32'd0, b_mag};
                        cnt_q   <= 6'd32;
                        neg_q   <= a_neg ^ b_neg;
                        rneg_q  <= a_neg;
                        div0_q  <= funct3[2] && (rs2_val == 32'd0);
                        busy    <= 1'b1;
                        state_q <= S_CALC;
`ifdef MULDIV_FAST_SPECIAL_EN
                        spec_q     <= is_special;
                        spec_res_q <= spec_res;
                        if (is_special) begin
                            state_q <= S_FIX;
                        end
`endif
                    end
                end
                S_CALC: begin
                    cnt_q <= cnt_q - 6'd1;
                    if (op_q[2]) begin
                        prod_q <= prod_div_d;
                        rem_q  <= rem_d;
                    end else begin
                        prod_q <= prod_mul_d;
                    end
                    if (cnt_q == 6'd1) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    wb_data <= fix_res;
                    wb_addr <= rd_q;
                    done    <= 1'b1;
                    wb_en   <= 1'b1;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    done    <= 1'b0;
                    wb_en   <= 1'b0;
                    busy    <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    done    <= 1'b0;
                    wb_en   <= 1'b0;
                    busy    <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected results queued at issue, compared when done pulses.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [4:0]  rd_addr;
    logic        busy;
    logic        done;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int done_cnt = 0;

`ifdef MULDIV_FAST_SPECIAL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    typedef struct {
        logic [31:0] data;
        logic [4:0]  addr;
        int          t0;
        int          lat;
        string       name;
    } exp_t;

    exp_t sb_q[$];

    muldiv_unit #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .start(start), .funct3(funct3),
        .rs1_val(rs1_val), .rs2_val(rs2_val), .rd_addr(rd_addr),
        .busy(busy), .done(done), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [63:0] p;
        logic        ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = 64'd0;
        case (f)
            3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
            3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
            3'd2: begin p = {{32{a[31]}}, a} * {32'd0, b}; return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: return (b == 32'd0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 :
                         32'($signed(a) / $signed(b));
            3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 32'd0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        bit special;
        special = (f[2] && (b == 32'd0)) ||
                  (((f == 3'b100) || (f == 3'b110)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) ||
                  (!f[2] && ((a == 32'd0) || (b == 32'd0)));
        return (FAST && special) ? 2 : 34;
    endfunction

    // Pops the scoreboard on every completion pulse.
    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1) begin
            done_cnt <= done_cnt + 1;
            if (sb_q.size() == 0) begin
                check_eq("spurious_done", 32'(done), 32'd0);
            end else begin
                e = sb_q.pop_front();
                check_eq({e.name, "_data"}, wb_data, e.data);
                check_eq({e.name, "_addr"}, 32'(wb_addr), 32'(e.addr));
                check_eq({e.name, "_wb_en"}, 32'(wb_en), 32'd1);
                check_eq({e.name, "_latency"}, 32'(cyc - e.t0), 32'(e.lat));
            end
        end
    end

    // Drive a request in the current cycle and queue its expected result.
    task automatic launch(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp, input string name);
        exp_t e;
        start   = 1'b1;
        funct3  = f;
        rs1_val = a;
        rs2_val = b;
        rd_addr = rd;
        e.data  = exp;
        e.addr  = rd;
        e.t0    = cyc;
        e.lat   = exp_lat(f, a, b);
        e.name  = name;
        sb_q.push_back(e);
    endtask

    task automatic wait_done(input string tag);
        int prev;
        int i;
        prev = done_cnt;
        i    = 0;
        while ((done_cnt == prev) && (i < 80)) begin
            @(negedge clk);
            #1;
            i++;
        end
        check_eq({tag, "_completed"}, 32'(done_cnt), 32'(prev + 1));
    endtask

    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp, input string name);
        @(negedge clk);
        launch(f, a, b, rd, exp, name);
        @(negedge clk);
        start   = 1'b0;
        funct3  = 3'($urandom);
        rs1_val = $urandom;
        rs2_val = $urandom;
        rd_addr = 5'($urandom);
        check_eq({name, "_busy"}, 32'(busy), 32'd1);
        wait_done(name);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          dc;
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        rst = 1'b1; start = 1'b0; funct3 = 3'd0; rs1_val = 32'd0; rs2_val = 32'd0; rd_addr = 5'd0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_wb_en", 32'(wb_en), 32'd0);
        check_eq("rst_wb_addr", 32'(wb_addr), 32'd0);
        check_eq("rst_wb_data", wb_data, 32'd0);
        rst = 1'b0;

        run_op(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, "mul");
        run_op(3'b001, 32'h8000_0000, 32'hFFFF_FFFF, 5'd1, 32'h0000_0000, "mulh");
        run_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 5'd2, 32'h8000_0000, "mulhsu");
        run_op(3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3, 32'h7FFF_FFFF, "mulhu");
        run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFD, "div");
        run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, "rem");
        run_op(3'b101, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'h7FFF_FFFC, "divu");
        run_op(3'b111, 32'hFFFF_FFF9, 32'd2, 5'd8, 32'd1, "remu");
        run_op(3'b100, 32'd7, 32'hFFFF_FFFE, 5'd9, 32'hFFFF_FFFD, "div_negdivisor");
        run_op(3'b110, 32'd7, 32'hFFFF_FFFE, 5'd9, 32'd1, "rem_negdivisor");
        run_op(3'b100, 32'h1234, 32'd0, 5'd10, 32'hFFFF_FFFF, "div_by0");
        run_op(3'b110, 32'h1234, 32'd0, 5'd11, 32'h1234, "rem_by0");
        run_op(3'b100, 32'hFFFF_FFFB, 32'd0, 5'd12, 32'hFFFF_FFFF, "div_neg_by0");
        run_op(3'b110, 32'hFFFF_FFFB, 32'd0, 5'd12, 32'hFFFF_FFFB, "rem_neg_by0");
        run_op(3'b101, 32'd5, 32'd0, 5'd13, 32'hFFFF_FFFF, "divu_by0");
        run_op(3'b111, 32'h8000_0001, 32'd0, 5'd14, 32'h8000_0001, "remu_by0");
        run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, "div_ovf");
        run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'd0, "rem_ovf");
        run_op(3'b000, 32'd0, 32'd12345, 5'd0, 32'd0, "mul_zero_x0");
        run_op(3'b001, 32'hFFFF_FFFF, 32'd0, 5'd17, 32'd0, "mulh_zero");

        for (int i = 0; i < 16; i++) begin
            f = 3'($urandom_range(0, 7));
            a = (i == 5) ? 32'd0 : $urandom;
            b = ((i % 4) == 0) ? 32'd0 : ((i % 4) == 1) ? 32'($urandom_range(1, 15)) : $urandom;
            run_op(f, a, b, 5'(i + 1), ref_model(f, a, b), "rand");
        end

        // Start pulses while busy and in DONE are ignored; the next IDLE cycle accepts.
        @(negedge clk);
        launch(3'b000, 32'd6, 32'd7, 5'd20, 32'd42, "busy_mul");
        for (int k = 1; k <= 34; k++) begin
            @(negedge clk);
            if ((k == 5) || (k == 34)) begin
                start = 1'b1; funct3 = 3'b100; rs1_val = 32'd100; rs2_val = 32'd3; rd_addr = 5'd21;
            end else begin
                start = 1'b0;
            end
            if (k == 5) check_eq("busy_c5", 32'(busy), 32'd1);
        end
        @(negedge clk);
        check_eq("idle_c35_busy", 32'(busy), 32'd0);
        launch(3'b100, 32'd100, 32'd3, 5'd21, 32'd33, "c35_div");
        @(negedge clk);
        start = 1'b0;
        wait_done("c35_div");

        // Reset in the middle of a divide discards it.
        @(negedge clk);
        start = 1'b1; funct3 = 3'b100; rs1_val = 32'hFFFF_FFF9; rs2_val = 32'd2; rd_addr = 5'd22;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("midrst_busy", 32'(busy), 32'd0);
        check_eq("midrst_done", 32'(done), 32'd0);
        check_eq("midrst_wb_data", wb_data, 32'd0);
        check_eq("midrst_wb_addr", 32'(wb_addr), 32'd0);
        dc = done_cnt;
        repeat (45) @(negedge clk);
        check_eq("midrst_no_done", 32'(done_cnt), 32'(dc));
        run_op(3'b000, 32'd3, 32'd4, 5'd23, 32'd12, "mul_after_rst");

        repeat (5) @(negedge clk);
        check_eq("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
